// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-timing derivation, receive FSM states and frame width.
// Used by uart_rx and the companion uart_tx.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int half_bit(input int cpb);
    return cpb / 2;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and wraps, restarts to 0 on request,
// and flags the half-period and full-period sample points.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 2604
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  output logic half_tick_o,
  output logic full_tick_o
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart_i || cnt_q == CW'(CLKS_PER_BIT - 1)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign half_tick_o = (cnt_q == CW'(HALF_BIT - 1));
  assign full_tick_o = (cnt_q == CW'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver with a one-byte holding register on a valid/ready interface,
// one-cycle framing-error pulse and sticky overrun flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 25000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       clr_overrun,
  output rx_state_e  dbg_state_o
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

  // Handshake: a byte transfers in any cycle where rx_valid && rx_ready are both high;
  // rx_data is held stable while rx_valid is high and rx_valid never drops without a transfer.

  logic sync1_q, rx_s_q;
  rx_state_e state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic valid_q, valid_d;
  logic frame_err_q, frame_err_d;
  logic overrun_q, overrun_d;
  logic half_tick, full_tick;

  // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= RxD;
      rx_s_q  <= sync1_q;
    end
  end

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .restart_i  (state_d != state_q),
    .half_tick_o(half_tick),
    .full_tick_o(full_tick)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q && !rx_ready;
    frame_err_d = 1'b0;
    overrun_d   = clr_overrun ? 1'b0 : overrun_q;

    case (state_q)
      RX_IDLE: begin
        if (!rx_s_q) state_d = RX_START;
      end
      RX_START: begin
        if (half_tick) begin
          if (!rx_s_q) begin
            state_d = RX_DATA;
            idx_d   = '0;
          end else begin
            state_d = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (full_tick) begin
          shift_d[idx_q] = rx_s_q;
          if (idx_q == 3'(DATA_BITS - 1)) begin
            state_d = RX_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      RX_STOP: begin
        if (full_tick) begin
          if (rx_s_q) begin
            // A byte being read out this same cycle frees the holding register.
            if (!valid_q || rx_ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
            state_d = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        if (rx_s_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RX_IDLE;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a scaled line rate (25 clocks per bit) so whole frames stay short.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CLK_NS  = 40;
  localparam int CPB     = 25;
  localparam int BIT_NS  = CPB * CLK_NS;

  logic       clk;
  logic       rst;
  logic       RxD;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       clr_overrun;
  rx_state_e  dbg_state;

  int checks   = 0;
  int failures = 0;
  int fe_cnt   = 0;
  int rise_cnt = 0;
  logic valid_prev = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx #(
    .CLK_FREQ(25000000),
    .BAUD    (1000000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .RxD        (RxD),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .clr_overrun(clr_overrun),
    .dbg_state_o(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #(CLK_NS / 2) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every accepted byte must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) fe_cnt++;
      if (rx_valid && !valid_prev) rise_cnt++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) check("unexpected_byte", {24'd0, rx_data}, 32'hffff_ffff);
        else check("rx_byte", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
    end
    valid_prev = rx_valid;
  end

  // Driver tasks
  task automatic send_byte(input logic [7:0] d, input logic stop);
    RxD = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      RxD = d[i];
      #(BIT_NS);
    end
    RxD = stop;
    #(BIT_NS);
  endtask

  task automatic idle_bits(input int n);
    #(n * BIT_NS);
    @(posedge clk);
    #1;
  endtask

  int fe0, rise0;
  logic found;

  initial begin
    rst = 1'b1; RxD = 1'b1; rx_ready = 1'b0; clr_overrun = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data", {24'd0, rx_data}, 32'h00);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(RX_IDLE));
    rst = 1'b0;
    idle_bits(1);

    // 1: single byte 0x05 with the consumer always ready
    rx_ready = 1'b1;
    fe0 = fe_cnt; rise0 = rise_cnt;
    exp_q.push_back(8'h05);
    send_byte(8'h05, 1'b1);
    idle_bits(2);
    check("t1_rises", rise_cnt - rise0, 1);
    check("t1_ferr", fe_cnt - fe0, 0);
    check("t1_ovr", {31'd0, overrun}, 32'd0);
    check("t1_valid", {31'd0, rx_valid}, 32'd0);
    check("t1_sb_empty", exp_q.size(), 0);

    // 2: back-to-back 0xA5, 0x3C with nobody reading -> overrun, 0xA5 held
    rx_ready = 1'b0;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    idle_bits(1);
    check("t2_valid", {31'd0, rx_valid}, 32'd1);
    check("t2_data", {24'd0, rx_data}, 32'hA5);
    check("t2_ovr_set", {31'd0, overrun}, 32'd1);
    clr_overrun = 1'b1;
    @(posedge clk); #1;
    clr_overrun = 1'b0;
    check("t2_ovr_clr", {31'd0, overrun}, 32'd0);
    check("t2_data_kept", {24'd0, rx_data}, 32'hA5);
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    check("t2_valid_fall", {31'd0, rx_valid}, 32'd0);
    check("t2_sb_empty", exp_q.size(), 0);

    // 3: 0x55 with a low stop bit and the line held low -> one frame_err, then 0x12
    rx_ready = 1'b1;
    fe0 = fe_cnt; rise0 = rise_cnt;
    send_byte(8'h55, 1'b0);
    #(3 * BIT_NS);
    check("t3_state_break", 32'(dbg_state), 32'(RX_BREAK));
    check("t3_ferr_once", fe_cnt - fe0, 1);
    check("t3_no_valid", rise_cnt - rise0, 0);
    RxD = 1'b1;
    idle_bits(2);
    check("t3_state_idle", 32'(dbg_state), 32'(RX_IDLE));
    exp_q.push_back(8'h12);
    send_byte(8'h12, 1'b1);
    idle_bits(1);
    check("t3_sb_empty", exp_q.size(), 0);
    check("t3_ferr_after", fe_cnt - fe0, 1);

    // 4: short low glitch on an idle line is rejected at the start-bit centre
    fe0 = fe_cnt; rise0 = rise_cnt;
    RxD = 1'b0;
    repeat (5) @(posedge clk);
    #1 RxD = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t4_state_start", 32'(dbg_state), 32'(RX_START));
    idle_bits(2);
    check("t4_state_idle", 32'(dbg_state), 32'(RX_IDLE));
    check("t4_no_valid", rise_cnt - rise0, 0);
    check("t4_no_ferr", fe_cnt - fe0, 0);

    // 5: reset during data bit 4, then a clean 0xFF
    RxD = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      RxD = i[0] ? 1'b0 : 1'b1;
      #(BIT_NS);
    end
    RxD = 1'b0;
    #(BIT_NS / 2);
    check("t5_state_data", 32'(dbg_state), 32'(RX_DATA));
    rst = 1'b1;
    RxD = 1'b1;
    #5;
    check("t5_rst_data", {24'd0, rx_data}, 32'h00);
    check("t5_rst_valid", {31'd0, rx_valid}, 32'd0);
    check("t5_rst_ferr", {31'd0, frame_err}, 32'd0);
    check("t5_rst_ovr", {31'd0, overrun}, 32'd0);
    check("t5_rst_state", 32'(dbg_state), 32'(RX_IDLE));
    #5;
    rst = 1'b0;
    idle_bits(2);
    rx_ready = 1'b0;
    send_byte(8'hFF, 1'b1);
    idle_bits(1);
    check("t5_valid", {31'd0, rx_valid}, 32'd1);
    check("t5_data", {24'd0, rx_data}, 32'hFF);
    exp_q.push_back(8'hFF);
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    check("t5_sb_empty", exp_q.size(), 0);

    // 6: read-out of 0x81 in the very cycle 0x7E delivers -> 0x7E loads, no overrun
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    idle_bits(1);
    check("t6_first_valid", {31'd0, rx_valid}, 32'd1);
    exp_q.push_back(8'h7E);
    found = 1'b0;
    fork
      send_byte(8'h7E, 1'b1);
      begin
        for (int i = 0; i < 20 * CPB && !found; i++) begin
          @(negedge clk);
          if (dbg_state == RX_STOP) found = 1'b1;
        end
        check("t6_stop_seen", {31'd0, found}, 32'd1);
        if (found) begin
          repeat (CPB - 1) @(posedge clk);
          #1 rx_ready = 1'b1;
          @(negedge clk);
          check("t6_old_data", {24'd0, rx_data}, 32'h81);
          @(posedge clk);
          #1 rx_ready = 1'b0;
          @(negedge clk);
          check("t6_new_data", {24'd0, rx_data}, 32'h7E);
          check("t6_valid_kept", {31'd0, rx_valid}, 32'd1);
          check("t6_no_ovr", {31'd0, overrun}, 32'd0);
        end
      end
    join
    idle_bits(1);
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    check("t6_sb_empty", exp_q.size(), 0);
    check("t6_valid_fall", {31'd0, rx_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receive front end that recovers 8N1 bytes from the asynchronous RxD pin.
- Feeds the UART register block: received bytes are presented on a valid/ready byte interface, with framing-error and overrun status.
- Sits directly upstream of the UART's CPU-visible receive data register.
- Defaults target the 25 MHz system clock (40 ns period) and 9600 baud (104167 ns per bit).

Parameters:
- CLK_FREQ, 25000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (2604, integer-truncated), clocks per bit period.
- HALF_BIT, CLKS_PER_BIT/2 (1302), clocks from start edge to start-bit centre.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- RxD  in  1  serial line; idle high; asynchronous to clk.
- rx_data  out  8  received byte, LSB = first data bit.
- rx_valid  out  1  rx_data holds an unread byte.
- rx_ready  in  1  consumer accepts the byte when rx_valid && rx_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  sticky: a byte was dropped because the holding register was full.
- clr_overrun  in  1  synchronous clear of overrun.

Behaviour:
- Reset values:
  - rx_data=0x00, rx_valid=0, frame_err=0, overrun=0.
  - Synchronizer flops=1, state=IDLE, bit counter=0, shift register=0.
- Input synchronizer: two-flop synchronizer on RxD gives rx_s (2-cycle latency). All decisions use rx_s only.
- Sample counter: cnt counts 0..CLKS_PER_BIT-1 and resets on every state entry.
- IDLE:
  - rx_s==0 moves to START with cnt=0.
- START:
  - At cnt==HALF_BIT-1, sample rx_s.
  - 0 moves to DATA (cnt=0, bit index=0).
  - 1 is a glitch or false start: return to IDLE and emit nothing.
- DATA:
  - At cnt==CLKS_PER_BIT-1, shift rx_s into bit[idx]; transmission is LSB first.
  - After idx 7, go to STOP.
- STOP: at cnt==CLKS_PER_BIT-1, sample rx_s.
  - 1: deliver the byte.
  - 0: frame_err=1 for exactly one cycle, discard the byte, go to BREAK.
- BREAK:
  - Wait for rx_s==1, then go to IDLE. A held-low line therefore produces one frame_err, not repeated ones.
- Delivery, in the cycle after the stop sample:
  - If rx_valid==0, or rx_valid && rx_ready in that same cycle: rx_data <= byte, rx_valid <= 1.
  - Otherwise: overrun <= 1, new byte dropped, old byte and rx_valid retained.
  - Then go to IDLE. The next start bit is detectable from the following cycle.
- Handshake:
  - rx_valid falls the cycle after rx_valid && rx_ready unless a new byte loads in that same cycle.
  - rx_data is stable while rx_valid==1.
- overrun:
  - Set by a dropped byte; cleared by clr_overrun.
  - A set and clr_overrun in the same cycle leaves it set.
- Latency:
  - rx_valid rises HALF_BIT + 9*CLKS_PER_BIT + 1 cycles after rx_s first reads 0.
  - Add 2 synchronizer cycles relative to the pin edge.
- Reset mid-frame: immediate return to reset values; any partial byte is lost.
- No parity, one stop bit, no oversampled majority vote (single centre sample).

Decomposition:
- Shared package uart_pkg:
  - CLKS_PER_BIT/HALF_BIT derivation functions.
  - rx state enum: IDLE, START, DATA, STOP, BREAK.
  - DATA_BITS=8 constant.
  - Reused later by uart_tx.
- One natural sub-module: uart_bit_timer, a counter with a restart input and half/full-period tick outputs, parameterised by CLKS_PER_BIT.

Test Plan:
- Drive RxD at 104167 ns/bit: start, data bits 1,0,1,0,0,0,0,0, stop; rx_ready=1.
  - Expect rx_valid pulse with rx_data=0x05, frame_err=0, overrun=0.
- Send 0xA5 then 0x3C back-to-back with rx_ready=0.
  - Expect rx_data=0xA5 held, overrun=1 after the second stop bit.
  - Then clr_overrun gives overrun=0.
- Send 0x55 with the stop bit driven 0 and the line held low for 3 bit times.
  - Expect exactly one frame_err pulse, rx_valid stays 0.
  - After the line returns high, a following 0x12 is received correctly.
- Drive a 20 µs low glitch on an idle line.
  - Expect no rx_valid and no frame_err; state returns to IDLE.
- Assert rst mid-frame (during data bit 4) for 10 ns, then send 0xFF.
  - Expect all outputs at reset values during rst, and rx_data=0xFF received afterwards.
- Pull rx_ready high in the same cycle a new byte delivers while rx_valid=1.
  - Expect the new byte loaded, rx_valid stays 1, overrun=0.
